// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, and shift the quotient bit in.
`ifdef ALU_MULDIV_DIV_EN
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_in < divisor always holds, so diff[XLEN] is a clean borrow flag.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule
`endif

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Divide/remainder datapath is built only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [1:0]      state_dbg
);

  // Handshake: start is sampled only in IDLE (busy=0); busy stays high in CALC
  // and FIN; done pulses for one cycle (in FIN) with result valid alongside it.

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state;
  muldiv_op_e        op_q;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic              res_neg;
  logic [CNT_W-1:0]  cnt;

  muldiv_op_e        op_in;
  logic              a_neg;
  logic              b_neg;
  logic              neg_in;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;

  logic              special_hit;
  logic              special_ill;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_res;
  logic [2*XLEN-1:0] step_next;
  logic [XLEN-1:0]   final_res;

  assign state_dbg = state;

  assign op_in    = muldiv_op_e'(funct3);
  assign a_neg    = op_signed_a(op_in) & op_a[XLEN-1];
  assign b_neg    = op_signed_b(op_in) & op_b[XLEN-1];
  assign mag_a_in = a_neg ? -op_a : op_a;
  assign mag_b_in = b_neg ? -op_b : op_b;
  // Remainder follows the dividend; quotient and products follow a^b.
  assign neg_in   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_hit = 1'b0;
    special_ill = 1'b0;
    special_res = '0;
    if (funct3[2]) begin
`ifdef ALU_MULDIV_DIV_EN
      if (op_b == '0) begin
        special_hit = 1'b1;
        special_res = funct3[1] ? op_a : '1;
      end else if (!funct3[0] && (op_a == INT_MIN) && (op_b == '1)) begin
        special_hit = 1'b1;
        special_res = funct3[1] ? '0 : op_a;
      end
`else
      special_hit = 1'b1;
      special_ill = 1'b1;
`endif
    end
  end

  // Shift-add: low half holds the remaining multiplier bits, high half the sum.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign mul_prod = res_neg ? -mul_next : mul_next;
  assign mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

`ifdef ALU_MULDIV_DIV_EN
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_val;
  logic [XLEN-1:0] div_res;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc[2*XLEN-1:XLEN]),
    .quo_in  (acc[XLEN-1:0]),
    .divisor (mag_b),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  assign div_val   = op_q[1] ? div_rem : div_quo;
  assign div_res   = res_neg ? -div_val : div_val;
  assign step_next = op_q[2] ? {div_rem, div_quo} : mul_next;
  assign final_res = op_q[2] ? div_res : mul_res;
`else
  assign step_next = mul_next;
  assign final_res = mul_res;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      acc     <= '0;
      mag_b   <= '0;
      op_q    <= OP_MUL;
      res_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            op_q    <= op_in;
            mag_b   <= mag_b_in;
            res_neg <= neg_in;
            acc     <= {{XLEN{1'b0}}, mag_a_in};
            cnt     <= CNT_W'(XLEN);
            busy    <= 1'b1;
            if (special_hit) begin
              result  <= special_res;
              illegal <= special_ill;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          // Fix-up is taken from the final step's value so done lands in FIN.
          if (cnt == CNT_W'(1)) begin
            result <= final_res;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq (XLEN=32); covers divide or the
// illegal-op path depending on ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
    logic        ill;
  } vec_t;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end

  // Driver: issue one op from a point just after a rising edge, follow it to done,
  // then step one more cycle so the caller is in IDLE.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ill, output int lat,
                       output logic busy_ok, output logic done_after);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge CLK); #1;
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = result;
    ill = illegal;
    @(posedge CLK); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    start = 1'b0;
    funct3 = 3'b000;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (illegal !== 1'b0)   begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_checks++; if (result !== 32'h0)   begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_mul();
    vec_t v [6];
    logic [31:0] res;
    logic ill, busy_ok, done_after;
    int lat;
    v[0] = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 8'd33, 1'b0};
    v[1] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 8'd33, 1'b0};
    v[2] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33, 1'b0};
    v[3] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 8'd33, 1'b0};
    v[4] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 8'd33, 1'b0};
    v[5] = '{3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 8'd33, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].f, v[i].a, v[i].b, res, ill, lat, busy_ok, done_after);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL mul[%0d]_result got=%h exp=%h", i, res, v[i].exp); end
      n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL mul[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL mul[%0d]_busy got=low exp=high throughout", i); end
      n_checks++; if (ill !== v[i].ill) begin n_fail++; $display("FAIL mul[%0d]_illegal got=%b exp=%b", i, ill, v[i].ill); end
      n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL mul[%0d]_done_width got=%b exp=0", i, done_after); end
    end
  endtask

`ifdef ALU_MULDIV_DIV_EN
  task automatic test_div();
    vec_t v [10];
    logic [31:0] res;
    logic ill, busy_ok, done_after;
    int lat;
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd33, 1'b0};
    v[1] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd33, 1'b0};
    v[2] = '{3'b101, 32'd100,      32'd7,        32'd14,       8'd33, 1'b0};
    v[3] = '{3'b111, 32'd100,      32'd7,        32'd2,        8'd33, 1'b0};
    v[4] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 8'd33, 1'b0};
    v[5] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        8'd33, 1'b0};
    v[6] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1,  1'b0};
    v[7] = '{3'b110, 32'd5,        32'd0,        32'd5,        8'd1,  1'b0};
    v[8] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1,  1'b0};
    v[9] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1,  1'b0};
    for (int i = 0; i < 10; i++) begin
      do_op(v[i].f, v[i].a, v[i].b, res, ill, lat, busy_ok, done_after);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL div[%0d]_result got=%h exp=%h", i, res, v[i].exp); end
      n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL div[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL div[%0d]_busy got=low exp=high throughout", i); end
      n_checks++; if (ill !== v[i].ill) begin n_fail++; $display("FAIL div[%0d]_illegal got=%b exp=%b", i, ill, v[i].ill); end
      n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL div[%0d]_done_width got=%b exp=0", i, done_after); end
    end
  endtask
`else
  task automatic test_illegal();
    vec_t v [3];
    logic [31:0] res;
    logic ill, busy_ok, done_after;
    int lat;
    v[0] = '{3'b100, 32'd10, 32'd2, 32'd0,  8'd1,  1'b1};
    v[1] = '{3'b111, 32'd7,  32'd0, 32'd0,  8'd1,  1'b1};
    v[2] = '{3'b000, 32'd3,  32'd4, 32'd12, 8'd33, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].f, v[i].a, v[i].b, res, ill, lat, busy_ok, done_after);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL ill[%0d]_result got=%h exp=%h", i, res, v[i].exp); end
      n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL ill[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_checks++; if (ill !== v[i].ill) begin n_fail++; $display("FAIL ill[%0d]_illegal got=%b exp=%b", i, ill, v[i].ill); end
      n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL ill[%0d]_done_width got=%b exp=0", i, done_after); end
    end
  endtask
`endif

  task automatic test_ignored_start();
    int lat;
    int extra_done;
    funct3 = 3'b000;
    op_a   = 32'd5;
    op_b   = 32'd6;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        start  = 1'b1;
        funct3 = 3'b011;
        op_a   = 32'hFFFFFFFF;
        op_b   = 32'hFFFFFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    n_checks++; if (result !== 32'd30) begin n_fail++; $display("FAIL ignored_start_result got=%h exp=%h", result, 32'd30); end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignored_start_latency got=%0d exp=33", lat); end
    extra_done = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) extra_done++;
    end
    n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL ignored_start_spurious_done got=%0d exp=0", extra_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    funct3 = 3'b000;
    op_a   = 32'd9;
    op_b   = 32'd9;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_checks++; if (result !== 32'h0)   begin n_fail++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got=%0d exp=0", state_dbg); end
    seen_done = 0;
    repeat (40) begin
      if (done) seen_done++;
      @(posedge CLK); #1;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen_done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic ill, busy_ok, done_after;
    int lat;
    do_op(3'b000, 32'd3, 32'd4, res, ill, lat, busy_ok, done_after);
    n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=%h", res, 32'd12); end
    do_op(3'b000, 32'h0000FFFF, 32'h0000FFFF, res, ill, lat, busy_ok, done_after);
    n_checks++; if (res !== 32'hFFFE0001) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=%h", res, 32'hFFFE0001); end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef ALU_MULDIV_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
